// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard-control bus: ID/EX/MEM hazard sources in, stage stall/flush controls out.
// Stall_cnt/Flush_cnt exist only when HAZARD_PERF_CNT_EN is defined.
interface hazard_ctrl_if;
  logic [4:0]  ID_rs1;
  logic [4:0]  ID_rs2;
  logic        ID_re1;
  logic        ID_re2;
  logic [4:0]  EX_wr;
  logic        EX_mem_rd;
  logic        EX_br_taken;
  logic        MEM_busy;
  logic        PC_stall;
  logic        IF_ID_stall;
  logic        ID_EX_stall;
  logic        EX_MEM_stall;
  logic        IF_ID_flush;
  logic        ID_EX_flush;
  logic        MEM_WB_flush;
  logic        mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] Stall_cnt;
  logic [31:0] Flush_cnt;

  modport slave (
    input  ID_rs1, ID_rs2, ID_re1, ID_re2, EX_wr, EX_mem_rd, EX_br_taken, MEM_busy,
    output PC_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall,
    output IF_ID_flush, ID_EX_flush, MEM_WB_flush, mem_timeout, Stall_cnt, Flush_cnt
  );
  modport master (
    output ID_rs1, ID_rs2, ID_re1, ID_re2, EX_wr, EX_mem_rd, EX_br_taken, MEM_busy,
    input  PC_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall,
    input  IF_ID_flush, ID_EX_flush, MEM_WB_flush, mem_timeout, Stall_cnt, Flush_cnt
  );
`else
  modport slave (
    input  ID_rs1, ID_rs2, ID_re1, ID_re2, EX_wr, EX_mem_rd, EX_br_taken, MEM_busy,
    output PC_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall,
    output IF_ID_flush, ID_EX_flush, MEM_WB_flush, mem_timeout
  );
  modport master (
    output ID_rs1, ID_rs2, ID_re1, ID_re2, EX_wr, EX_mem_rd, EX_br_taken, MEM_busy,
    input  PC_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall,
    input  IF_ID_flush, ID_EX_flush, MEM_WB_flush, mem_timeout
  );
`endif
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, memory-wait stalls, sticky timeout.
// Optional performance counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT       = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [1:0] LU_INIT = 2'(LOAD_STALL_CYCLES - 1);
  localparam logic [7:0] TMO     = 8'(MEM_TIMEOUT);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_lu_cnt;
  logic [1:0] w_lu_cnt_nxt;
  logic [7:0] r_wait_cnt;
  logic [7:0] w_wait_cnt_nxt;
  logic       r_mem_timeout;
  logic       w_load_use;
  logic       w_pc_stall;
  logic       w_if_id_stall;
  logic       w_id_ex_stall;
  logic       w_ex_mem_stall;
  logic       w_if_id_flush;
  logic       w_id_ex_flush;
  logic       w_mem_wb_flush;

  assign w_load_use = hz.EX_mem_rd && (hz.EX_wr != 5'd0) &&
                      ((hz.ID_re1 && (hz.ID_rs1 == hz.EX_wr)) ||
                       (hz.ID_re2 && (hz.ID_rs2 == hz.EX_wr)));

  // Busy cycles are counted in every state; the count restarts once memory completes.
  assign w_wait_cnt_nxt = hz.MEM_busy ? sat_inc8(r_wait_cnt) : 8'd0;

  // Next-state and stage control decode; priority MEM_busy > branch > load-use.
  always_comb begin
    w_state_nxt    = r_state;
    w_lu_cnt_nxt   = r_lu_cnt;
    w_pc_stall     = 1'b0;
    w_if_id_stall  = 1'b0;
    w_id_ex_stall  = 1'b0;
    w_ex_mem_stall = 1'b0;
    w_if_id_flush  = 1'b0;
    w_id_ex_flush  = 1'b0;
    w_mem_wb_flush = 1'b0;
    if (hz.MEM_busy) begin
      w_pc_stall     = 1'b1;
      w_if_id_stall  = 1'b1;
      w_id_ex_stall  = 1'b1;
      w_ex_mem_stall = 1'b1;
      w_mem_wb_flush = 1'b1;
    end else begin
      w_pc_stall = 1'b0;
    end
    case (r_state)
      RUN, MEM_WAIT: begin
        if (hz.MEM_busy) begin
          w_state_nxt = MEM_WAIT;
        end else if (hz.EX_br_taken) begin
          w_if_id_flush = 1'b1;
          w_id_ex_flush = 1'b1;
          w_state_nxt   = RUN;
        end else if (w_load_use) begin
          w_pc_stall    = 1'b1;
          w_if_id_stall = 1'b1;
          w_id_ex_flush = 1'b1;
          if (LU_INIT == 2'd0) begin
            w_state_nxt = RUN;
          end else begin
            w_state_nxt  = LU_STALL;
            w_lu_cnt_nxt = LU_INIT;
          end
        end else begin
          w_state_nxt = RUN;
        end
      end
      LU_STALL: begin
        if (hz.MEM_busy) begin
          w_state_nxt = LU_STALL;
        end else begin
          w_pc_stall    = 1'b1;
          w_if_id_stall = 1'b1;
          w_id_ex_flush = 1'b1;
          w_lu_cnt_nxt  = r_lu_cnt - 2'd1;
          w_state_nxt   = (r_lu_cnt == 2'd1) ? RUN : LU_STALL;
        end
      end
      default: begin
        w_state_nxt  = RUN;
        w_lu_cnt_nxt = 2'd0;
      end
    endcase
  end

  // State, stall counter, wait counter and sticky timeout registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= RUN;
      r_lu_cnt      <= 2'd0;
      r_wait_cnt    <= 8'd0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_lu_cnt   <= w_lu_cnt_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (hz.MEM_busy && (w_wait_cnt_nxt == TMO)) begin
        r_mem_timeout <= 1'b1;
      end else begin
        r_mem_timeout <= r_mem_timeout;
      end
    end
  end

  assign hz.PC_stall     = w_pc_stall;
  assign hz.IF_ID_stall  = w_if_id_stall;
  assign hz.ID_EX_stall  = w_id_ex_stall;
  assign hz.EX_MEM_stall = w_ex_mem_stall;
  assign hz.IF_ID_flush  = w_if_id_flush;
  assign hz.ID_EX_flush  = w_id_ex_flush;
  assign hz.MEM_WB_flush = w_mem_wb_flush;
  assign hz.mem_timeout  = r_mem_timeout;

`ifdef HAZARD_PERF_CNT_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  // Saturating counts of PC stall cycles and IF/ID flush cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      r_stall_cnt <= w_pc_stall    ? sat_inc32(r_stall_cnt) : r_stall_cnt;
      r_flush_cnt <= w_if_id_flush ? sat_inc32(r_flush_cnt) : r_flush_cnt;
    end
  end

  assign hz.Stall_cnt = r_stall_cnt;
  assign hz.Flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench: dut_a (LOAD_STALL_CYCLES=1) and dut_b (LOAD_STALL_CYCLES=3, MEM_TIMEOUT=10)
// share one stimulus stream; outputs are checked at the falling edge.
module tb_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] ID_rs1, ID_rs2, EX_wr;
  logic       ID_re1, ID_re2, EX_mem_rd, EX_br_taken, MEM_busy;
  int         total = 0;
  int         passes = 0;

  localparam logic [6:0] NONE = 7'b000_0000;
  localparam logic [6:0] LU   = 7'b110_0010;
  localparam logic [6:0] BR   = 7'b000_0110;
  localparam logic [6:0] MEM  = 7'b111_1001;

  always #5 clk = ~clk;

  hazard_ctrl_if ifa ();
  hazard_ctrl_if ifb ();

  assign ifa.ID_rs1 = ID_rs1;      assign ifb.ID_rs1 = ID_rs1;
  assign ifa.ID_rs2 = ID_rs2;      assign ifb.ID_rs2 = ID_rs2;
  assign ifa.ID_re1 = ID_re1;      assign ifb.ID_re1 = ID_re1;
  assign ifa.ID_re2 = ID_re2;      assign ifb.ID_re2 = ID_re2;
  assign ifa.EX_wr = EX_wr;        assign ifb.EX_wr = EX_wr;
  assign ifa.EX_mem_rd = EX_mem_rd;     assign ifb.EX_mem_rd = EX_mem_rd;
  assign ifa.EX_br_taken = EX_br_taken; assign ifb.EX_br_taken = EX_br_taken;
  assign ifa.MEM_busy = MEM_busy;  assign ifb.MEM_busy = MEM_busy;

  hazard_ctrl #(.LOAD_STALL_CYCLES(1)) dut_a (.clk(clk), .rst_n(rst_n), .hz(ifa.slave));
  hazard_ctrl #(.LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(10)) dut_b (.clk(clk), .rst_n(rst_n), .hz(ifb.slave));

  wire [6:0] out_a = {ifa.PC_stall, ifa.IF_ID_stall, ifa.ID_EX_stall, ifa.EX_MEM_stall,
                      ifa.IF_ID_flush, ifa.ID_EX_flush, ifa.MEM_WB_flush};
  wire [6:0] out_b = {ifb.PC_stall, ifb.IF_ID_stall, ifb.ID_EX_stall, ifb.EX_MEM_stall,
                      ifb.IF_ID_flush, ifb.ID_EX_flush, ifb.MEM_WB_flush};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic drive(input logic mrd, input logic [4:0] wr, input logic [4:0] rs1,
                       input logic re1, input logic [4:0] rs2, input logic re2,
                       input logic br, input logic busy);
    EX_mem_rd = mrd; EX_wr = wr; ID_rs1 = rs1; ID_re1 = re1;
    ID_rs2 = rs2; ID_re2 = re2; EX_br_taken = br; MEM_busy = busy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("reset_out_a", 32'(out_a), 32'(NONE));
    chk("reset_out_b", 32'(out_b), 32'(NONE));
    chk("reset_tmo_b", 32'(ifb.mem_timeout), 32'd0);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_b", 32'(out_b), 32'(NONE));

    // isolated load-use on rs1
    next_cycle();
    drive(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("lu1_a", 32'(out_a), 32'(LU));
    chk("lu1_b", 32'(out_b), 32'(LU));
    next_cycle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("lu2_a", 32'(out_a), 32'(NONE));
    chk("lu2_b", 32'(out_b), 32'(LU));
    next_cycle();
    @(negedge clk);
    chk("lu3_b", 32'(out_b), 32'(LU));
    next_cycle();
    @(negedge clk);
    chk("lu4_b", 32'(out_b), 32'(NONE));

    // EX_wr = 0 never hazards; rs2 match ignored when re2 = 0
    next_cycle();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("x0_b", 32'(out_b), 32'(NONE));
    next_cycle();
    drive(1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("re2off_b", 32'(out_b), 32'(NONE));

    // branch beats a simultaneous load-use
    next_cycle();
    drive(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("br_a", 32'(out_a), 32'(BR));
    chk("br_b", 32'(out_b), 32'(BR));
    next_cycle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("br_after_b", 32'(out_b), 32'(NONE));
`ifdef HAZARD_PERF_CNT_EN
    chk("stall_cnt_b", ifb.Stall_cnt, 32'd3);
    chk("flush_cnt_b", ifb.Flush_cnt, 32'd1);
    chk("stall_cnt_a", ifa.Stall_cnt, 32'd1);
`endif

    // load-use on rs2, then 4 busy cycles inside the stall
    next_cycle();
    drive(1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("lu_rs2_b", 32'(out_b), 32'(LU));
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      chk($sformatf("lubusy%0d_a", k), 32'(out_a), 32'(MEM));
      chk($sformatf("lubusy%0d_b", k), 32'(out_b), 32'(MEM));
    end
    next_cycle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("luresume1_a", 32'(out_a), 32'(NONE));
    chk("luresume1_b", 32'(out_b), 32'(LU));
    next_cycle();
    @(negedge clk);
    chk("luresume2_b", 32'(out_b), 32'(LU));
    next_cycle();
    @(negedge clk);
    chk("luresume3_b", 32'(out_b), 32'(NONE));
    chk("short_busy_tmo_b", 32'(ifb.mem_timeout), 32'd0);

    // 12 busy cycles: timeout after the 10th
    for (int k = 1; k <= 12; k++) begin
      next_cycle();
      drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      chk($sformatf("busy%0d_b", k), 32'(out_b), 32'(MEM));
      chk($sformatf("tmo%0d_b", k), 32'(ifb.mem_timeout), (k >= 11) ? 32'd1 : 32'd0);
    end
    chk("tmo_a", 32'(ifa.mem_timeout), 32'd0);
    next_cycle();
    drive(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("wait_br_a", 32'(out_a), 32'(BR));
    chk("wait_br_b", 32'(out_b), 32'(BR));
    next_cycle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("tmo_sticky_b", 32'(ifb.mem_timeout), 32'd1);

    // reset in the middle of a load-use stall
    next_cycle();
    drive(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rstlu1_b", 32'(out_b), 32'(LU));
    next_cycle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rstlu2_b", 32'(out_b), 32'(LU));
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_b", 32'(out_b), 32'(NONE));
    chk("rst_mid_tmo_b", 32'(ifb.mem_timeout), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    chk("rst_stall_cnt_b", ifb.Stall_cnt, 32'd0);
    chk("rst_flush_cnt_b", ifb.Flush_cnt, 32'd0);
`endif
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_b", 32'(out_b), 32'(NONE));
    next_cycle();
    @(negedge clk);
    chk("post_rst2_b", 32'(out_b), 32'(NONE));

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter LOAD_STALL_CYCLES, default 1, number of bubble cycles inserted per load-use hazard (legal 1..3).
REQ-002 SHALL have parameter MEM_TIMEOUT, default 255, maximum MEM_busy cycles before timeout is flagged (legal 1..255).
REQ-003 SHALL have ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- ID_rs1, ID_rs2  in  5 each  source registers of the instruction in ID.
- ID_re1, ID_re2  in  1 each  ID instruction reads rs1/rs2.
- EX_wr  in  5  destination register of the instruction in EX.
- EX_mem_rd  in  1  instruction in EX is a load.
- EX_br_taken  in  1  branch/jump resolved taken in EX.
- MEM_busy  in  1  data-memory access in MEM not complete.
- PC_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall  out  1 each  hold the register.
- IF_ID_flush, ID_EX_flush, MEM_WB_flush  out  1 each  load a bubble into the register.
- mem_timeout  out  1  sticky error flag.

Function
REQ-004 SHALL implement a 3-state FSM (RUN, LU_STALL, MEM_WAIT) and a 2-bit stall counter lu_cnt; outputs are combinational from state and current inputs.
REQ-005 SHALL detect load-use as: EX_mem_rd && EX_wr!=0 && ((ID_re1 && ID_rs1==EX_wr) || (ID_re2 && ID_rs2==EX_wr)).
REQ-006 Per-cycle priority SHALL be MEM_busy > EX_br_taken > load-use.
REQ-007 RUN, MEM_busy=1: assert PC_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall, MEM_WB_flush; next MEM_WAIT.
REQ-008 RUN, EX_br_taken=1 (MEM_busy=0): assert IF_ID_flush, ID_EX_flush for that cycle only; stay RUN; any load-use this cycle ignored.
REQ-009 RUN, load-use (no higher event): assert PC_stall, IF_ID_stall, ID_EX_flush; if LOAD_STALL_CYCLES==1 stay RUN, else next LU_STALL with lu_cnt=LOAD_STALL_CYCLES-1.
REQ-010 LU_STALL, MEM_busy=0: assert PC_stall, IF_ID_stall, ID_EX_flush; decrement lu_cnt; next RUN when lu_cnt==1; load-use and EX_br_taken not evaluated.
REQ-011 LU_STALL, MEM_busy=1: outputs as REQ-007; lu_cnt held; stay LU_STALL.
REQ-012 MEM_WAIT, MEM_busy=1: outputs as REQ-007; increment wait counter (8-bit, saturating).
REQ-013 MEM_WAIT, MEM_busy=0: outputs and next state evaluated exactly as RUN with MEM_busy=0; wait counter cleared.
REQ-014 mem_timeout SHALL set on the clock edge where the wait counter reaches MEM_TIMEOUT with MEM_busy=1, and remain set until reset.
REQ-015 Total stall cycles per isolated load-use SHALL equal LOAD_STALL_CYCLES exactly.
REQ-016 Outputs not named as asserted in a case SHALL be 0.

Reset
REQ-017 rst_n=0 SHALL immediately force state RUN, lu_cnt=0, wait counter=0, mem_timeout=0, performance counters 0.
REQ-018 Reset asserted mid-stall or mid-wait SHALL abandon the operation; the first cycle after release behaves as RUN.

Configuration
REQ-019 Macro HAZARD_PERF_CNT_EN defined: SHALL add outputs Stall_cnt[31:0] (increments each cycle PC_stall=1) and Flush_cnt[31:0] (increments each cycle IF_ID_flush=1), both saturating at 32'hFFFF_FFFF.
REQ-020 HAZARD_PERF_CNT_EN undefined: these ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-021 LOAD_STALL_CYCLES=1; EX_mem_rd=1, EX_wr=5, ID_rs1=5, ID_re1=1 -> one cycle PC_stall=IF_ID_stall=ID_EX_flush=1, next cycle all 0.
REQ-022 LOAD_STALL_CYCLES=3, same stimulus held one cycle -> stall/bubble asserted exactly 3 consecutive cycles; EX_wr=0 with identical stimulus -> no stall.
REQ-023 EX_br_taken=1 together with load-use match -> IF_ID_flush=ID_EX_flush=1, PC_stall=0, one cycle only.
REQ-024 MEM_busy=1 for 4 cycles during LU_STALL with lu_cnt=2 -> all four stalls plus MEM_WB_flush for 4 cycles, then remaining 2 load-use stall cycles.
REQ-025 MEM_TIMEOUT=10, MEM_busy held 12 cycles -> mem_timeout rises after 10th busy cycle, stays 1 after MEM_busy drops, clears only on rst_n=0.
REQ-026 With HAZARD_PERF_CNT_EN, test REQ-022 (3-cycle case) then REQ-023 -> Stall_cnt=3, Flush_cnt=1; rst_n pulse mid-stall -> both 0, state RUN.
